// File: rtl/xoddr_serdes_if.sv
// Word handshake into the DDR output serializer: one word of NBEATS beats, NLANES pins.
// Ports: i_valid/i_data/i_oe from the source, o_ready back from the serializer.
// Source holds i_valid and the word stable until o_ready is seen high on a clock edge.
interface xoddr_serdes_if #(
    parameter int NLANES = 4,
    parameter int NBEATS = 4
);
    logic                            i_valid;
    logic                            o_ready;
    logic [2*NLANES*NBEATS-1:0]      i_data;
    logic [NLANES-1:0]               i_oe;

    modport master (output i_valid, i_data, i_oe, input o_ready);
    modport slave  (input i_valid, i_data, i_oe, output o_ready);
endinterface

// File: rtl/xoddr_serdes.sv
// Multi-lane DDR output serializer: shifts a word out one beat per clock, two bits per lane per beat.
// Latency: word accepted at edge k puts beat 0 on o_pin in cycle k+2 (hi half, then lo half).
// Backpressure: o_ready high in IDLE and on the last shifting beat, so words stream gap-free.
// Ports: i_clk, i_reset (async, active high), s_in (word handshake), o_pin (DDR pads),
//        o_oe (tristate enable aligned to o_pin), o_busy (word shifting or still in the pipeline).
module xoddr_serdes #(
    parameter int                NLANES     = 4,
    parameter int                NBEATS     = 4,
    parameter logic [NLANES-1:0] IDLE_VALUE = '1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    xoddr_serdes_if.slave     s_in,
    output logic [NLANES-1:0] o_pin,
    output logic [NLANES-1:0] o_oe,
    output logic              o_busy
);
    localparam int BW = 2 * NLANES;        // bits per beat (hi half + lo half)
    localparam int DW = BW * NBEATS;       // bits per word
    localparam int CW = $clog2(NBEATS + 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     shreg_q;
    logic [CW-1:0]     cnt_q;
    logic [NLANES-1:0] word_oe_q;
    logic [BW-1:0]     beat_q;
    logic [NLANES-1:0] beat_oe_q;
    logic              beat_vld_q;
    logic              pin_vld_q;
    logic              ready;
    logic              accept;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (s_in.i_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Last beat leaving the shift register: a new word may be
                // loaded on this edge so its beat 0 directly follows.
                ready = (cnt_q == CW'(1));
                if (ready && !s_in.i_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        accept = ready && s_in.i_valid;
    end

    assign s_in.o_ready = ready;

    // ---------------------------------------------------------------
    // Shift register, beat register and the oe/valid pipeline that
    // tracks each beat through to the pads.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            word_oe_q  <= '0;
            beat_q     <= {IDLE_VALUE, IDLE_VALUE};
            beat_oe_q  <= '0;
            beat_vld_q <= 1'b0;
            o_oe       <= '0;
            pin_vld_q  <= 1'b0;
        end else begin
            if (state_q == ST_SHIFT) begin
                beat_q     <= shreg_q[DW-1 -: BW];
                beat_oe_q  <= word_oe_q;
                beat_vld_q <= 1'b1;
            end else begin
                beat_q     <= {IDLE_VALUE, IDLE_VALUE};
                beat_oe_q  <= '0;
                beat_vld_q <= 1'b0;
            end

            // A reload on the last beat wins over the shift; the old last
            // beat has already been captured into beat_q above.
            if (accept) begin
                shreg_q   <= s_in.i_data;
                cnt_q     <= CW'(NBEATS);
                word_oe_q <= s_in.i_oe;
            end else if (state_q == ST_SHIFT) begin
                shreg_q <= shreg_q << BW;
                cnt_q   <= cnt_q - CW'(1);
            end

            // Same stage as the ODDR capture, so o_oe lines up with o_pin.
            o_oe      <= beat_oe_q;
            pin_vld_q <= beat_vld_q;
        end
    end

    assign o_busy = (state_q == ST_SHIFT) || beat_vld_q || pin_vld_q;

    // ---------------------------------------------------------------
    // One ODDR per lane: SAME_EDGE, D1 = hi half, D2 = lo half,
    // CE tied high, S tied low, INIT 0, R = i_reset (async).
    // Both halves are captured on the rising edge; D1 drives the pad
    // while the clock is high, D2 while it is low.
    // ---------------------------------------------------------------
    for (genvar l = 0; l < NLANES; l++) begin : g_oddr
        logic d1_q;
        logic d2_q;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                d1_q <= 1'b0;
                d2_q <= 1'b0;
            end else begin
                d1_q <= beat_q[NLANES + l];
                d2_q <= beat_q[l];
            end
        end

        assign o_pin[l] = i_clk ? d1_q : d2_q;
    end
endmodule

// File: tb/tb_xoddr_serdes.sv
module tb_xoddr_serdes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Main configuration: 4 lanes, 4 beats, idle F
    xoddr_serdes_if #(.NLANES(4), .NBEATS(4)) m_if();
    logic [3:0] m_pin, m_oe;
    logic       m_busy;
    xoddr_serdes #(.NLANES(4), .NBEATS(4), .IDLE_VALUE(4'hF)) dut_m (
        .i_clk(clk), .i_reset(rst), .s_in(m_if),
        .o_pin(m_pin), .o_oe(m_oe), .o_busy(m_busy)
    );

    // Single-lane, single-beat corner
    xoddr_serdes_if #(.NLANES(1), .NBEATS(1)) a_if();
    logic [0:0] a_pin, a_oe;
    logic       a_busy;
    xoddr_serdes #(.NLANES(1), .NBEATS(1), .IDLE_VALUE(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .s_in(a_if),
        .o_pin(a_pin), .o_oe(a_oe), .o_busy(a_busy)
    );

    // Dual-lane corner with a non-trivial idle level
    xoddr_serdes_if #(.NLANES(2), .NBEATS(2)) b_if();
    logic [1:0] b_pin, b_oe;
    logic       b_busy;
    xoddr_serdes #(.NLANES(2), .NBEATS(2), .IDLE_VALUE(2'b01)) dut_b (
        .i_clk(clk), .i_reset(rst), .s_in(b_if),
        .o_pin(b_pin), .o_oe(b_oe), .o_busy(b_busy)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
        logic [3:0]  ioe;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [3:0]  oe;
        logic        rdy;
        logic        busy;
    } row_t;

    row_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (clock high, hi half showing).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check both halves of the main DUT's current cycle, then step.
    task automatic beat_m(input string tag, input logic [3:0] hi, input logic [3:0] lo,
                          input logic [3:0] oe);
        check({tag, " hi"}, 32'(m_pin), 32'(hi));
        check({tag, " oe"}, 32'(m_oe), 32'(oe));
        @(negedge clk);
        #1;
        check({tag, " lo"}, 32'(m_pin), 32'(lo));
        step();
    endtask

    initial begin
        logic [3:0] rh [4];
        logic [3:0] rl [4];
        logic [1:0] d1 [6];

        m_if.i_valid = 1'b0; m_if.i_data = '0; m_if.i_oe = '0;
        a_if.i_valid = 1'b0; a_if.i_data = '0; a_if.i_oe = '0;
        b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_oe = '0;

        // {vld, data, i_oe, exp hi, exp lo, exp oe, exp ready, exp busy}
        // Single word
        tbl[0]  = '{1'b1, 32'hA53C_0F96, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 32'h0,         4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,         4'h0, 4'hA, 4'h5, 4'hF, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,         4'h0, 4'h3, 4'hC, 4'hF, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,         4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,         4'h0, 4'h9, 4'h6, 4'hF, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,         4'h0, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
        // Back-to-back with the second word held under backpressure
        tbl[8]  = '{1'b1, 32'h1234_5678, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'h9ABC_DEF0, 4'h1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'h9ABC_DEF0, 4'h1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 32'h9ABC_DEF0, 4'h1, 4'h1, 4'h2, 4'hF, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 32'h9ABC_DEF0, 4'h1, 4'h3, 4'h4, 4'hF, 1'b1, 1'b1};
        // Data without valid must be ignored
        tbl[13] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'h5, 4'h6, 4'hF, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'h7, 4'h8, 4'hF, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'h9, 4'hA, 4'h1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'hB, 4'hC, 4'h1, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'hD, 4'hE, 4'h1, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 32'hDEAD_BEEF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};

        // ---------------- Reset state ----------------
        #2;
        check("rst pin lo-phase", 32'(m_pin), 32'h0);
        check("rst oe", 32'(m_oe), 32'h0);
        check("rst ready", 32'(m_if.o_ready), 32'h1);
        check("rst busy", 32'(m_busy), 32'h0);
        step();
        check("rst pin hi-phase", 32'(m_pin), 32'h0);
        #1 rst = 1'b0;
        step();
        beat_m("idle after reset", 4'hF, 4'hF, 4'h0);
        check("idle ready", 32'(m_if.o_ready), 32'h1);
        check("idle busy", 32'(m_busy), 32'h0);
        check("b idle pin", 32'(b_pin), 32'h1);

        // ---------------- Table-driven main sequences ----------------
        for (int i = 0; i < 20; i++) begin
            m_if.i_valid = tbl[i].vld;
            m_if.i_data  = tbl[i].dat;
            m_if.i_oe    = tbl[i].ioe;
            check($sformatf("row%0d ready", i), 32'(m_if.o_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d busy", i), 32'(m_busy), 32'(tbl[i].busy));
            beat_m($sformatf("row%0d", i), tbl[i].hi, tbl[i].lo, tbl[i].oe);
        end

        // ---------------- Reset mid-word ----------------
        m_if.i_valid = 1'b1; m_if.i_data = 32'h5AC3_F069; m_if.i_oe = 4'hF;
        step();                                  // accepted at edge k
        m_if.i_valid = 1'b0; m_if.i_data = '0;
        step();                                  // k+1
        step();                                  // k+2
        beat_m("mid beat0", 4'h5, 4'hA, 4'hF);   // -> k+3
        beat_m("mid beat1", 4'hC, 4'h3, 4'hF);   // -> k+4
        #1;
        check("mid beat2 before rst", 32'(m_pin), 32'hF);
        rst = 1'b1;
        #1;
        check("mid rst pin", 32'(m_pin), 32'h0);
        check("mid rst oe", 32'(m_oe), 32'h0);
        check("mid rst ready", 32'(m_if.o_ready), 32'h1);
        check("mid rst busy", 32'(m_busy), 32'h0);
        @(negedge clk); #1;
        check("mid rst pin lo", 32'(m_pin), 32'h0);
        step();
        check("mid rst pin next", 32'(m_pin), 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post rst busy%0d", i), 32'(m_busy), 32'h0);
            beat_m($sformatf("post rst idle%0d", i), 4'hF, 4'hF, 4'h0);
        end
        rh = '{4'h1, 4'h5, 4'h9, 4'hD};
        rl = '{4'h3, 4'h7, 4'hB, 4'hF};
        m_if.i_valid = 1'b1; m_if.i_data = 32'h1357_9BDF; m_if.i_oe = 4'h3;
        check("post rst ready", 32'(m_if.o_ready), 32'h1);
        step();
        m_if.i_valid = 1'b0; m_if.i_data = '0;
        beat_m("post word k", 4'hF, 4'hF, 4'h0);
        beat_m("post word k+1", 4'hF, 4'hF, 4'h0);
        for (int j = 0; j < 4; j++) begin
            beat_m($sformatf("post word beat%0d", j), rh[j], rl[j], 4'h3);
        end
        check("post word busy end", 32'(m_busy), 32'h0);
        beat_m("post word idle", 4'hF, 4'hF, 4'h0);

        // ---------------- NLANES=1, NBEATS=1 stream ----------------
        d1 = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 10; i++) begin
            int j;
            j = i - 3;
            if (i < 6) begin
                a_if.i_valid = 1'b1; a_if.i_data = d1[i]; a_if.i_oe = 1'b1;
            end else begin
                a_if.i_valid = 1'b0; a_if.i_data = 2'b00; a_if.i_oe = 1'b0;
            end
            check($sformatf("s1 ready%0d", i), 32'(a_if.o_ready), 32'h1);
            if (j >= 0 && j < 6) begin
                check($sformatf("s1 hi%0d", i), 32'(a_pin), 32'(d1[j][1]));
                check($sformatf("s1 oe%0d", i), 32'(a_oe), 32'h1);
                @(negedge clk); #1;
                check($sformatf("s1 lo%0d", i), 32'(a_pin), 32'(d1[j][0]));
                check($sformatf("s1 ready lo%0d", i), 32'(a_if.o_ready), 32'h1);
            end else begin
                check($sformatf("s1 idle hi%0d", i), 32'(a_pin), 32'h1);
                check($sformatf("s1 idle oe%0d", i), 32'(a_oe), 32'h0);
                @(negedge clk); #1;
                check($sformatf("s1 idle lo%0d", i), 32'(a_pin), 32'h1);
            end
            step();
        end
        check("s1 busy end", 32'(a_busy), 32'h0);

        // ---------------- NLANES=2 lane order ----------------
        b_if.i_valid = 1'b1; b_if.i_data = 8'h9C; b_if.i_oe = 2'b10;
        step();
        b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_oe = '0;
        check("d2 k idle", 32'(b_pin), 32'h1);
        check("d2 k busy", 32'(b_busy), 32'h1);
        step();
        check("d2 k+1 idle", 32'(b_pin), 32'h1);
        step();
        check("d2 beat0 hi", 32'(b_pin), 32'h2);
        check("d2 beat0 msb lane", 32'(b_pin[1]), 32'h1);
        check("d2 beat0 oe", 32'(b_oe), 32'h2);
        @(negedge clk); #1;
        check("d2 beat0 lo", 32'(b_pin), 32'h1);
        step();
        check("d2 beat1 hi", 32'(b_pin), 32'h3);
        @(negedge clk); #1;
        check("d2 beat1 lo", 32'(b_pin), 32'h0);
        step();
        check("d2 idle hi", 32'(b_pin), 32'h1);
        check("d2 idle oe", 32'(b_oe), 32'h0);
        check("d2 busy end", 32'(b_busy), 32'h0);
        @(negedge clk); #1;
        check("d2 idle lo", 32'(b_pin), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/xoddr_serdes.md
# xoddr_serdes

Parametrised multi-lane DDR output serializer for the flash controllers' I/O pads. It accepts a word of `NBEATS` beats over a valid/ready handshake and shifts it out, one beat per clock, across `NLANES` pins. Every beat carries two bits per lane, driven through one ODDR primitive per lane. It also drives a registered per-lane output enable and a defined idle level, so controllers no longer hand-pipeline DDR pin pairs.

## Interface
- `NLANES`, default 4: number of output pins (1 = SPI, 2 = dual, 4 = quad).
- `NBEATS`, default 4: clock beats per accepted word; must be ≥1.
- `IDLE_VALUE`, default all ones, width `NLANES`: level driven on each pin when no word is shifting.
- `i_clk`, input, 1: the only clock; all logic is on the rising edge.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: `i_data`/`i_oe` hold a word to send.
- `o_ready`, output, 1: block will accept a word this cycle.
- `i_data`, input, 2·NLANES·NBEATS: beat 0 in the MSBs. Within a beat, the upper NLANES bits form the first half-cycle and the lower NLANES bits form the second.
- `i_oe`, input, NLANES: per-lane output enable for the whole word.
- `o_pin`, output, NLANES: DDR pad outputs.
- `o_oe`, output, NLANES: registered tristate enable, aligned to `o_pin`.
- `o_busy`, output, 1: a word is shifting, or the output pipeline still holds beats.

## Operation
- Two states.
  - IDLE: `o_ready`=1; pins drive `IDLE_VALUE` on both halves; `o_oe`=0.
  - SHIFT: a shift register holds the remaining beats, and a down-counter of width `$clog2(NBEATS+1)` holds the beats left.
- Accept on `i_valid && o_ready`:
  - load shift register ← `i_data`, counter ← `NBEATS`, oe register ← `i_oe`;
  - enter SHIFT.
- Each SHIFT cycle:
  - the top 2·NLANES bits of the shift register are registered into the beat register (hi half, lo half);
  - the shift register shifts left 2·NLANES bits, zero-filling;
  - the counter decrements.
- `o_ready`=1 in SHIFT when counter==1, so back-to-back words stream with no gap. An accept on that cycle reloads instead of returning to IDLE.
- Counter reaching 0 with no accept returns the state to IDLE.
- `NBEATS`=1: `o_ready` stays 1 permanently, so one word per clock is sustainable.
- Each lane's ODDR uses the same settings:
  - SAME_EDGE clocking;
  - D1 = hi-half bit (driven during the first half-cycle), D2 = lo-half bit;
  - CE=1, INIT=0, SRTYPE="ASYNC", R=`i_reset`, S=0.
- Pin level in IDLE: `IDLE_VALUE` on both halves.
- `o_oe` comes from a register that tracks the beat register: it equals the word's `i_oe` while that word's beats are on the pins, and 0 otherwise.
- `i_data` is ignored when not accepted; `i_valid` while `o_ready`=0 has no effect, and the source must hold it.

## Timing
- Reset values:
  - `o_ready`=1, `o_busy`=0, `o_oe`=0;
  - counter 0, state IDLE;
  - beat register = {`IDLE_VALUE`,`IDLE_VALUE`};
  - `o_pin`=0 while `i_reset` is high (ODDR async reset), then `IDLE_VALUE` from the first clock after release.
- Latency, with acceptance at rising edge k:
  - beat 0 is in the beat register after edge k+1;
  - beat 0 appears on `o_pin` in cycle k+2: hi half first, lo half second;
  - `o_oe` changes in the same cycle as `o_pin`;
  - beat j appears in cycle k+2+j.
- `o_busy` rises the cycle after acceptance. It falls two cycles after the last beat leaves the shift register, once the pipeline is drained.
- Reset mid-word: the word is discarded immediately and asynchronously; pins go to 0 and `o_oe` to 0. After release the block is in IDLE with `o_ready`=1, and no partial beats are emitted.
- Simultaneous last-beat and accept: the new beat 0 directly follows the old last beat, and `o_oe` switches on that beat boundary.

## Test plan
- **Reset:** assert `i_reset` asynchronously mid-cycle → `o_pin`=0, `o_oe`=0 immediately. After release, idle pins = 4'hF on both halves, `o_ready`=1, `o_busy`=0.
- **Single word:** NLANES=4, NBEATS=4, `i_data`=32'hA5_3C_0F_96, `i_oe`=4'hF, accepted at edge k → pins show A/5, 3/C, 0/F, 9/6 (hi/lo) in cycles k+2…k+5. `o_oe`=F for exactly those 4 cycles, then the idle level F returns.
- **Back-to-back:** two words with `i_valid` held → `o_ready` pulses exactly on the last beat of each word. Eight consecutive beats appear with no idle gap; `o_oe` changes from 4'hF to 4'h1 on the boundary when `i_oe` differs.
- **Backpressure:** `i_valid` high throughout first word → second word's data is held unchanged until accept and is emitted intact. No beat is duplicated or lost.
- **Reset mid-word:** pulse `i_reset` after beat 1 → beats 2–3 never appear. The next word after release appears with the normal k+2 latency.
- **Corner parameters:**
  - NBEATS=1, NLANES=1: a continuous stream emits one 2-bit beat per clock, and `o_ready` is never 0.
  - NLANES=2: data maps to the correct lane order (MSB lane = `o_pin[NLANES-1]`).
